layer_feed_ctrl: RTL and testbench

- Upstream controller for the stack of five shift_layer stages.
- Generates a pseudo-random, always-reachable 7-block row (map plus block type) with an LFSR.
- Fills the layer chain after reset, then on each scroll request presents a new top row and sequences the start pulse and the 150 ms scroll window.
- Sits between the game FSM (scroll_req/scroll_done) and the chained shift_layer instances (load/start/layer_map/block_type).

---
 rtl/layer_feed_ctrl_pkg.sv | 60 ++++++
 rtl/layer_feed_ctrl_row_lfsr_gen.sv | 43 ++++
 rtl/layer_feed_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_layer_feed_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_feed_ctrl_pkg.sv
// rtl/layer_feed_ctrl_pkg.sv - shared types, constants and row helpers for layer_feed_ctrl
package layer_feed_ctrl_pkg;

    localparam int ROW_W            = 7;
    localparam int DEF_SCROLL_TICKS = 150;

    // Galois mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ARM,
        S_SCROLL,
        S_SETTLE
    } state_t;

    typedef struct packed {
        logic [0:ROW_W-1] map;
        logic [0:ROW_W-1] btype;
    } row_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        logic [15:0] nxt;
        nxt = cur >> 1;
        if (cur[0]) begin
            nxt = nxt ^ LFSR_TAPS;
        end
        return nxt;
    endfunction

    // Guarantees the candidate row touches the previous row or one of its
    // horizontal neighbours; otherwise the block at the lowest index of the
    // previous row is forced in so the player always has a landing spot.
    function automatic logic [0:ROW_W-1] reach_fix(input logic [0:ROW_W-1] cand,
                                                   input logic [0:ROW_W-1] prev);
        logic [0:ROW_W-1] reach;
        logic [0:ROW_W-1] lowest;
        reach  = prev | (prev << 1) | (prev >> 1);
        lowest = '0;
        for (int i = ROW_W - 1; i >= 0; i--) begin
            if (prev[i]) begin
                lowest    = '0;
                lowest[i] = 1'b1;
            end
        end
        if ((cand & reach) == '0) begin
            return cand | lowest;
        end
        return cand;
    endfunction

    function automatic row_t gen_row(input logic [15:0] lfsr, input logic [0:ROW_W-1] prev);
        row_t r;
        r.map   = reach_fix(lfsr[ROW_W-1:0], prev);
        r.btype = lfsr[2*ROW_W-1:ROW_W] & r.map;
        return r;
    endfunction

endpackage

// File: rtl/layer_feed_ctrl_row_lfsr_gen.sv
// rtl/layer_feed_ctrl_row_lfsr_gen.sv - LFSR and reachable candidate row generator
// Purpose: free-running 16-bit Galois LFSR (held while en_i is low) and the
//          combinational candidate row derived from it and the previous row.
// Ports:   clk_i, rst_i (sync, active-high), en_i advance enable,
//          prev_row_i last row handed to the layer chain,
//          row_map_o / row_type_o candidate map and block type (type subset of map).
module row_lfsr_gen
    import layer_feed_ctrl_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [0:ROW_W-1] prev_row_i,
    output logic [0:ROW_W-1] row_map_o,
    output logic [0:ROW_W-1] row_type_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    row_t        row;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign row        = gen_row(lfsr_q, prev_row_i);
    assign row_map_o  = row.map;
    assign row_type_o = row.btype;

endmodule

// File: rtl/layer_feed_ctrl.sv
// rtl/layer_feed_ctrl.sv - row feeder and scroll sequencer for the shift_layer chain
// Purpose: fills the layer chain after reset, then per scroll request presents
//          a new top row, pulses start and times the scroll window.
// Ports:   clk, rst (sync, active-high), module_en global hold, one_ms_tick strobe,
//          scroll_req from game FSM; load/start pulses, layer_map/block_type row,
//          init_done, scroll_busy, scroll_done back to the game FSM.
module layer_feed_ctrl
    import layer_feed_ctrl_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          N_LAYERS     = 5,
    parameter int          SCROLL_TICKS = DEF_SCROLL_TICKS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             module_en,
    input  logic             one_ms_tick,
    input  logic             scroll_req,
    output logic             load,
    output logic             start,
    output logic [0:ROW_W-1] layer_map,
    output logic [0:ROW_W-1] block_type,
    output logic             init_done,
    output logic             scroll_busy,
    output logic             scroll_done
);

    localparam logic [2:0] LAST_LAYER = 3'(N_LAYERS);
    localparam logic [7:0] TICK_END   = 8'(SCROLL_TICKS);
    localparam logic [0:ROW_W-1] FULL_ROW = '1;

    state_t           state_q, state_d;
    logic [2:0]       init_cnt_q, init_cnt_d;
    logic             init_ph_q, init_ph_d;
    logic             settle_q, settle_d;
    logic [7:0]       tick_cnt_q, tick_cnt_d;
    logic [7:0]       tick_inc;
    logic [0:ROW_W-1] prev_row_q, prev_row_d;
    logic [0:ROW_W-1] map_q, map_d;
    logic [0:ROW_W-1] type_q, type_d;
    logic             load_q, load_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             init_done_q, init_done_d;
    logic [0:ROW_W-1] gen_map;
    logic [0:ROW_W-1] gen_type;

    row_lfsr_gen #(
        .LFSR_SEED (LFSR_SEED)
    ) u_gen (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (module_en),
        .prev_row_i (prev_row_q),
        .row_map_o  (gen_map),
        .row_type_o (gen_type)
    );

    assign tick_inc = tick_cnt_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_ph_d   = init_ph_q;
        settle_d    = settle_q;
        tick_cnt_d  = tick_cnt_q;
        prev_row_d  = prev_row_q;
        map_d       = map_q;
        type_d      = type_q;
        busy_d      = busy_q;
        init_done_d = init_done_q;
        // pulses never stretch, even while the block is held
        load_d      = 1'b0;
        start_d     = 1'b0;
        done_d      = 1'b0;

        if (module_en) begin
            case (state_q)
                S_INIT: begin
                    // init_ph_q=0: load the row on the bus; =1: present the next row
                    if (!init_ph_q) begin
                        load_d     = 1'b1;
                        prev_row_d = map_q;
                        init_cnt_d = init_cnt_q + 3'd1;
                        init_ph_d  = 1'b1;
                    end else begin
                        init_ph_d = 1'b0;
                        if (init_cnt_q == LAST_LAYER) begin
                            init_done_d = 1'b1;
                            state_d     = S_IDLE;
                        end else begin
                            map_d  = gen_map;
                            type_d = gen_type;
                        end
                    end
                end
                S_IDLE: begin
                    if (scroll_req) begin
                        map_d      = gen_map;
                        type_d     = gen_type;
                        prev_row_d = gen_map;
                        state_d    = S_ARM;
                    end
                end
                S_ARM: begin
                    start_d    = 1'b1;
                    busy_d     = 1'b1;
                    tick_cnt_d = '0;
                    state_d    = S_SCROLL;
                end
                S_SCROLL: begin
                    // a tick in the same cycle as the start pulse belongs to the previous window
                    if (one_ms_tick && !start_q) begin
                        tick_cnt_d = tick_inc;
                        if (tick_inc == TICK_END) begin
                            settle_d = 1'b0;
                            state_d  = S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    // two cycles for the layers to reach their end state and latch
                    if (settle_q) begin
                        settle_d = 1'b0;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        settle_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT;
            init_cnt_q  <= '0;
            init_ph_q   <= 1'b0;
            settle_q    <= 1'b0;
            tick_cnt_q  <= '0;
            prev_row_q  <= FULL_ROW;
            map_q       <= FULL_ROW;
            type_q      <= '0;
            load_q      <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_ph_q   <= init_ph_d;
            settle_q    <= settle_d;
            tick_cnt_q  <= tick_cnt_d;
            prev_row_q  <= prev_row_d;
            map_q       <= map_d;
            type_q      <= type_d;
            load_q      <= load_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            init_done_q <= init_done_d;
        end
    end

    assign load        = load_q;
    assign start       = start_q;
    assign layer_map   = map_q;
    assign block_type  = type_q;
    assign init_done   = init_done_q;
    assign scroll_busy = busy_q;
    assign scroll_done = done_q;

endmodule

// File: tb/tb_layer_feed_ctrl.sv
// tb/tb_layer_feed_ctrl.sv - self-checking bench for layer_feed_ctrl
module tb_layer_feed_ctrl;
    import layer_feed_ctrl_pkg::*;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          NT   = 150;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       module_en = 1'b1;
    logic       one_ms_tick = 1'b0;
    logic       scroll_req = 1'b0;
    logic       load, start, init_done, scroll_busy, scroll_done;
    logic [0:6] layer_map, block_type;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] lfsr_m;
    logic [0:6]  prev_m;

    always #5 clk = ~clk;

    layer_feed_ctrl #(
        .LFSR_SEED    (SEED),
        .N_LAYERS     (5),
        .SCROLL_TICKS (NT)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .module_en   (module_en),
        .one_ms_tick (one_ms_tick),
        .scroll_req  (scroll_req),
        .load        (load),
        .start       (start),
        .layer_map   (layer_map),
        .block_type  (block_type),
        .init_done   (init_done),
        .scroll_busy (scroll_busy),
        .scroll_done (scroll_done)
    );

    // reference: polynomial x^16+x^14+x^13+x^11+1, Galois form, one step per enabled cycle
    function automatic logic [15:0] ref_step(input logic [15:0] l);
        logic [15:0] n;
        n = {1'b0, l[15:1]};
        if (l[0]) begin
            n[15] = ~n[15];
            n[13] = ~n[13];
            n[12] = ~n[12];
            n[10] = ~n[10];
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (rst) lfsr_m <= SEED;
        else if (module_en) lfsr_m <= ref_step(lfsr_m);
    end

    function automatic bit reach_ok(input logic [0:6] row, input logic [0:6] prev);
        for (int i = 0; i < 7; i++)
            if (row[i])
                for (int j = i - 1; j <= i + 1; j++)
                    if (j >= 0 && j < 7 && prev[j]) return 1'b1;
        return 1'b0;
    endfunction

    // returns {map, type}, both in index order 0..6
    function automatic logic [13:0] ref_row(input logic [15:0] l, input logic [0:6] prev);
        logic [0:6] c;
        logic [0:6] t;
        int lo;
        for (int i = 0; i < 7; i++) c[i] = l[6 - i];
        if (!reach_ok(c, prev)) begin
            lo = -1;
            for (int i = 0; i < 7; i++) if (prev[i] && lo < 0) lo = i;
            if (lo >= 0) c[lo] = 1'b1;
        end
        for (int i = 0; i < 7; i++) t[i] = c[i] & l[13 - i];
        return {c, t};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] lfsr;
        logic [0:6]  prev;
        logic [0:6]  exp_map;
        logic [0:6]  exp_type;
    } vec_t;

    task automatic run_table();
        vec_t vecs[8];
        row_t rr;
        vecs[0] = '{{2'b00, 7'b1111111, 7'b1110000}, 7'b0000001, 7'b1110001, 7'b1110001};
        vecs[1] = '{{2'b00, 7'b0101010, 7'b0000000}, 7'b1111111, 7'b1000000, 7'b0000000};
        vecs[2] = '{{2'b00, 7'b0000000, 7'b0000000}, 7'b0010100, 7'b0010000, 7'b0000000};
        vecs[3] = '{{2'b00, 7'b1111111, 7'b0100000}, 7'b0001000, 7'b0101000, 7'b0101000};
        vecs[4] = '{{2'b00, 7'b0000000, 7'b0010000}, 7'b0001000, 7'b0010000, 7'b0000000};
        vecs[5] = '{{2'b00, 7'b0000001, 7'b1000001}, 7'b0100000, 7'b1000001, 7'b0000001};
        vecs[6] = '{{2'b00, 7'b1000000, 7'b0000001}, 7'b1000000, 7'b1000001, 7'b1000000};
        vecs[7] = '{{2'b00, 7'b1111111, 7'b0000001}, 7'b0000010, 7'b0000001, 7'b0000001};
        for (int i = 0; i < 8; i++) begin
            rr = gen_row(vecs[i].lfsr, vecs[i].prev);
            chk($sformatf("table_map[%0d]", i), rr.map, vecs[i].exp_map);
            chk($sformatf("table_type[%0d]", i), rr.btype, vecs[i].exp_type);
        end
    endtask

    task automatic do_reset();
        logic [13:0] r;
        logic [0:6]  nxt_map;
        logic [0:6]  nxt_type;
        @(negedge clk);
        rst = 1'b1; scroll_req = 1'b0; one_ms_tick = 1'b0; module_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_load", load, 0);
        chk("rst_start", start, 0);
        chk("rst_map", layer_map, 7'h7f);
        chk("rst_type", block_type, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_busy", scroll_busy, 0);
        chk("rst_done", scroll_done, 0);
        chk("rst_lfsr", u_dut.u_gen.lfsr_q, SEED);
        rst = 1'b0;
        prev_m = 7'h7f; nxt_map = 7'h7f; nxt_type = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            chk("init_load", load, (c % 2 == 1 && c <= 9));
            chk("init_done", init_done, (c >= 10));
            chk("init_start", start, 0);
            chk("init_scroll_done", scroll_done, 0);
            if (c % 2 == 1 && c <= 9) begin
                chk("init_map", layer_map, nxt_map);
                chk("init_type", block_type, nxt_type);
                prev_m = nxt_map;
                if (c < 9) begin
                    r = ref_row(lfsr_m, prev_m);
                    nxt_map = r[13:7]; nxt_type = r[6:0];
                end
            end
        end
    endtask

    task automatic do_scroll(input int period, input int gap_at, input int gap_len,
                             input int spur_at, input int abort_at);
        logic [13:0] r;
        logic [0:6]  exp_map;
        logic [0:6]  exp_type;
        logic [15:0] l_hold;
        int counted;
        int cyc;
        bit gap_done;
        bit t;
        @(negedge clk);
        r = ref_row(lfsr_m, prev_m);
        exp_map = r[13:7]; exp_type = r[6:0];
        scroll_req = 1'b1;
        @(negedge clk);
        scroll_req = 1'b0;
        chk("acc_map", layer_map, exp_map);
        chk("acc_type", block_type, exp_type);
        chk("acc_reachable", reach_ok(layer_map, prev_m), 1);
        chk("acc_type_subset", block_type & ~layer_map, 0);
        chk("acc_start_early", start, 0);
        prev_m = exp_map;
        @(negedge clk);
        chk("start", start, 1);
        chk("busy_at_start", scroll_busy, 1);
        one_ms_tick = 1'b1;
        counted = 0; cyc = 0; gap_done = 1'b0;
        while (counted < NT && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            chk("hold_map", layer_map, exp_map);
            chk("hold_type", block_type, exp_type);
            chk("no_start", start, 0);
            chk("no_done", scroll_done, 0);
            chk("busy", scroll_busy, 1);
            chk("lfsr_track", u_dut.u_gen.lfsr_q, lfsr_m);
            if (abort_at > 0 && counted == abort_at) begin
                one_ms_tick = 1'b0;
                return;
            end
            if (gap_at > 0 && counted == gap_at && !gap_done) begin
                gap_done = 1'b1;
                l_hold = lfsr_m;
                module_en = 1'b0;
                for (int g = 0; g < gap_len * period; g++) begin
                    one_ms_tick = (g % period == 0);
                    @(negedge clk);
                    chk("gap_map", layer_map, exp_map);
                    chk("gap_busy", scroll_busy, 1);
                    chk("gap_done", scroll_done, 0);
                end
                chk("lfsr_frozen", u_dut.u_gen.lfsr_q, l_hold);
                module_en = 1'b1;
            end
            t = (cyc % period) == 0;
            one_ms_tick = t;
            scroll_req = (spur_at > 0 && counted >= spur_at && counted < spur_at + 3);
            if (t) counted++;
        end
        chk("ticks_reached", counted, NT);
        @(negedge clk);
        one_ms_tick = 1'b0;
        scroll_req = 1'b1;
        chk("settle0_done", scroll_done, 0);
        chk("settle0_busy", scroll_busy, 1);
        @(negedge clk);
        chk("settle1_done", scroll_done, 0);
        @(negedge clk);
        scroll_req = 1'b0;
        chk("done", scroll_done, 1);
        chk("busy_clear", scroll_busy, 0);
        chk("done_map", layer_map, exp_map);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("done_single", scroll_done, 0);
            chk("no_queued_start", start, 0);
            chk("post_hold_map", layer_map, exp_map);
        end
    endtask

    task automatic idle_rows(input int n);
        logic [13:0] r;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            module_en = ($urandom_range(0, 3) != 0);
            r = ref_row(lfsr_m, prev_m);
            chk("cand_map", u_dut.u_gen.row_map_o, r[13:7]);
            chk("cand_type", u_dut.u_gen.row_type_o, r[6:0]);
            chk("cand_reach", reach_ok(u_dut.u_gen.row_map_o, prev_m), 1);
            chk("idle_start", start, 0);
        end
        @(negedge clk);
        module_en = 1'b1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        run_table();
        do_reset();
        do_scroll(10, 0, 0, 0, 0);
        do_scroll(10, 0, 0, 50, 0);
        do_scroll(10, 60, 20, 0, 0);
        do_scroll(10, 0, 0, 0, 75);
        do_reset();
        idle_rows(3000);
        for (int k = 0; k < 6; k++) begin
            do_scroll($urandom_range(1, 3),
                      ($urandom_range(0, 1) != 0) ? $urandom_range(10, 140) : 0,
                      $urandom_range(1, 5),
                      ($urandom_range(0, 1) != 0) ? $urandom_range(1, 140) : 0,
                      0);
            idle_rows(300);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
